rfa_bank_arbiter: RTL

Per-cycle arbiter that shares the four VGPR read banks among the eight issue queues (simd0-3, simf0-3) feeding the register-file access stage. Each queue presents at most one pending operand-read request tagged with a target bank. The block grants at most one requester per bank per cycle, using rotating priority per bank plus a starvation override. It sits between the FU issue queues and the VGPR/SGPR port mux, alongside the existing rfa.

---
 rtl/rfa_bank_arbiter_if.sv | 20 ++
 rtl/rfa_bank_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/rfa_bank_arbiter_if.sv
// rtl/rfa_bank_arbiter_if.sv - request/grant bundle between the issue queues and the VGPR bank arbiter
interface rfa_bank_arbiter_if;
   logic [7:0]  req_valid;
   logic [15:0] req_bank;
   logic [3:0]  bank_busy;
   logic [7:0]  req_serviced;
   logic [3:0]  bank_grant_valid;
   logic [31:0] bank_grant_sel;
   logic [7:0]  starved;

   modport master (
      output req_valid, req_bank, bank_busy,
      input  req_serviced, bank_grant_valid, bank_grant_sel, starved
   );

   modport slave (
      input  req_valid, req_bank, bank_busy,
      output req_serviced, bank_grant_valid, bank_grant_sel, starved
   );
endinterface

// File: rtl/rfa_bank_arbiter.sv
// rtl/rfa_bank_arbiter.sv - per-bank rotating-priority arbiter with starvation override for 8 issue queues
module rfa_bank_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   rfa_bank_arbiter_if.slave bus
);
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [3:0][2:0]       ptr_q, ptr_d;
   logic [7:0][CNT_W-1:0] wcnt_q, wcnt_d;
   logic [7:0]            starved_q, starved_d;
   logic [3:0][7:0]       cand;
   logic [3:0][7:0]       sel;
   logic [3:0]            grant_valid;
   logic [7:0]            serviced;

   // Descending scans so the last hit is the lowest index / nearest to the pointer.
   function automatic logic [7:0] pick(input logic [7:0] c, input logic [7:0] stv,
                                       input logic [2:0] p);
      logic [7:0] hot;
      logic [7:0] res;
      logic [2:0] idx;
      hot = c & stv;
      res = '0;
      if (|hot) begin
         for (int k = 7; k >= 0; k--) begin
            if (hot[k]) begin
               res    = '0;
               res[k] = 1'b1;
            end
         end
      end else begin
         for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (c[idx]) begin
               res      = '0;
               res[idx] = 1'b1;
            end
         end
      end
      return res;
   endfunction

   function automatic logic [2:0] enc(input logic [7:0] s);
      logic [2:0] idx;
      idx = '0;
      for (int k = 0; k < 8; k++) begin
         if (s[k]) idx = 3'(k);
      end
      return idx;
   endfunction

   always_comb begin
      serviced = '0;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            cand[b][i] = bus.req_valid[i] && (bus.req_bank[2*i +: 2] == 2'(b));
         end
         sel[b]         = (rst || bus.bank_busy[b]) ? 8'h00 : pick(cand[b], starved_q, ptr_q[b]);
         grant_valid[b] = |sel[b];
         serviced       = serviced | sel[b];
         ptr_d[b]       = grant_valid[b] ? enc(sel[b]) + 3'd1 : ptr_q[b];
      end
      for (int i = 0; i < 8; i++) begin
         if (!bus.req_valid[i] || serviced[i]) begin
            wcnt_d[i] = '0;
         end else if (wcnt_q[i] == CNT_MAX) begin
            wcnt_d[i] = wcnt_q[i];
         end else begin
            wcnt_d[i] = wcnt_q[i] + CNT_W'(1);
         end
         starved_d[i] = (wcnt_d[i] >= LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= '0;
         wcnt_q    <= '0;
         starved_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         wcnt_q    <= wcnt_d;
         starved_q <= starved_d;
      end
   end

   assign bus.bank_grant_sel   = sel;
   assign bus.bank_grant_valid = grant_valid;
   assign bus.req_serviced     = serviced;
   assign bus.starved          = starved_q;
endmodule
